// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: FSM states, error codes,
// RV32I major opcodes and the opcode classifier used during DECODE/EXECUTE.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_IMEM_TO = 2'b10,
    ERR_DMEM_TO = 2'b11
  } err_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int unsigned TO_CNT_W = 8;

  // Sequencing class: decides which stages an instruction visits.
  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } opclass_e;

  function automatic opclass_e classify(input logic [6:0] opcode);
    opclass_e cls;
    case (opcode)
      OPC_R, OPC_I, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: cls = CLS_ALU;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_timeout_counter.sv
// Wait-cycle counter shared by the imem fetch and dmem access handshakes.
// expired is high in the last permitted wait cycle.
module mem_timeout_counter
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_CNT_W-1:0] LP_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != LP_LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LP_LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with gated
// write enables, memory handshake timeouts and a retired-instruction counter.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             w_en_rf_dec,
  input  logic             wr_en_dmem_dec,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             wr_en_dmem,
  output logic             w_en_rf,
  output logic             pc_en,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e     r_state;
  state_e     w_next_state;
  err_e       r_err;
  err_e       w_err_new;
  logic       w_err_set;
  opclass_e   w_opclass;
  logic       w_to_clear;
  logic       w_to_en;
  logic       w_to_expired;
  logic [CNT_W-1:0] r_retired;
  logic       w_unused_instr;

  assign w_opclass      = classify(instr[6:0]);
  assign w_unused_instr = ^instr[31:7];

  // Counter restarts on every state change, so back-to-back waits
  // (MEMORY -> FETCH) each get the full budget.
  assign w_to_clear = (w_next_state != r_state);
  assign w_to_en    = ((r_state == ST_FETCH)  && !imem_ack) ||
                      ((r_state == ST_MEMORY) && !dmem_ack);

  mem_timeout_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_to_clear),
    .enable  (w_to_en),
    .expired (w_to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_err_set    = 1'b0;
    w_err_new    = ERR_NONE;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    dmem_req     = 1'b0;
    wr_en_dmem   = 1'b0;
    w_en_rf      = 1'b0;
    pc_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_next_state = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load      = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_to_expired) begin
          w_next_state = ST_HALT;
          w_err_set    = 1'b1;
          w_err_new    = ERR_IMEM_TO;
        end
      end

      ST_DECODE: begin
        if (w_opclass == CLS_ILLEGAL) begin
          w_next_state = ST_HALT;
          w_err_set    = 1'b1;
          w_err_new    = ERR_ILLEGAL;
        end else begin
          w_next_state = ST_EXECUTE;
        end
      end

      ST_EXECUTE: begin
        case (w_opclass)
          CLS_LOAD, CLS_STORE: w_next_state = ST_MEMORY;
          CLS_BRANCH: begin
            pc_en        = 1'b1;
            w_next_state = ST_FETCH;
          end
          default:             w_next_state = ST_WRITEBACK;
        endcase
      end

      ST_MEMORY: begin
        dmem_req   = 1'b1;
        wr_en_dmem = wr_en_dmem_dec;
        if (dmem_ack) begin
          if (w_opclass == CLS_STORE) begin
            pc_en        = 1'b1;
            w_next_state = ST_FETCH;
          end else begin
            w_next_state = ST_WRITEBACK;
          end
        end else if (w_to_expired) begin
          w_next_state = ST_HALT;
          w_err_set    = 1'b1;
          w_err_new    = ERR_DMEM_TO;
        end
      end

      ST_WRITEBACK: begin
        w_en_rf      = w_en_rf_dec;
        pc_en        = 1'b1;
        w_next_state = ST_FETCH;
      end

      ST_HALT: begin
        w_next_state = ST_HALT;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= ERR_NONE;
    end else if (w_err_set && (r_err == ERR_NONE)) begin
      r_err <= w_err_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (pc_en) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign halted   = (r_state == ST_HALT);
  assign err_code = r_err;
  assign state    = r_state;
  assign retired  = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: cycle-by-cycle expected strobes and state
// for ALU, load, store, branch, illegal opcode, timeouts and reset.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ack;
  logic        dmem_ack;
  logic        w_en_rf_dec;
  logic        wr_en_dmem_dec;
  logic        imem_req;
  logic        ir_load;
  logic        dmem_req;
  logic        wr_en_dmem;
  logic        w_en_rf;
  logic        pc_en;
  logic        halted;
  logic [1:0]  err_code;
  logic [2:0]  state;
  logic [31:0] retired;

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [31:0] INSTR_ADD = 32'h0020_8033;
  localparam logic [31:0] INSTR_LW  = 32'h0000_A083;
  localparam logic [31:0] INSTR_SW  = 32'h0020_A023;
  localparam logic [31:0] INSTR_BEQ = 32'h0020_8063;
  localparam logic [31:0] INSTR_ILL = 32'h0000_007F;

  cpu_sequencer #(
    .TIMEOUT_CYC (15),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .imem_ack       (imem_ack),
    .dmem_ack       (dmem_ack),
    .w_en_rf_dec    (w_en_rf_dec),
    .wr_en_dmem_dec (wr_en_dmem_dec),
    .imem_req       (imem_req),
    .ir_load        (ir_load),
    .dmem_req       (dmem_req),
    .wr_en_dmem     (wr_en_dmem),
    .w_en_rf        (w_en_rf),
    .pc_en          (pc_en),
    .halted         (halted),
    .err_code       (err_code),
    .state          (state),
    .retired        (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] w_outs;
  assign w_outs = {state, imem_req, ir_load, dmem_req, wr_en_dmem, w_en_rf, pc_en, halted};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {state, imem_req, ir_load, dmem_req, wr_en_dmem, w_en_rf, pc_en, halted}
  function automatic logic [9:0] o(input int st, input bit ir, input bit il, input bit dr,
                                   input bit wd, input bit wr, input bit pc, input bit h);
    logic [2:0] s;
    s = st[2:0];
    return {s, ir, il, dr, wd, wr, pc, h};
  endfunction

  // Inputs are set just after a rising edge; outputs checked 1 ns later,
  // then the bench advances to just after the next edge and clears the acks.
  task automatic row(input string tag, input logic [9:0] exp);
    #1;
    check(tag, 64'(w_outs), 64'(exp));
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  logic [9:0] O_IDLE, O_FWAIT, O_FACK, O_DEC, O_EXE, O_HALT;

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    instr          = '0;
    imem_ack       = 1'b0;
    dmem_ack       = 1'b0;
    w_en_rf_dec    = 1'b0;
    wr_en_dmem_dec = 1'b0;
    O_IDLE  = o(0, 0, 0, 0, 0, 0, 0, 0);
    O_FWAIT = o(1, 1, 0, 0, 0, 0, 0, 0);
    O_FACK  = o(1, 1, 1, 0, 0, 0, 0, 0);
    O_DEC   = o(2, 0, 0, 0, 0, 0, 0, 0);
    O_EXE   = o(3, 0, 0, 0, 0, 0, 0, 0);
    O_HALT  = o(7, 0, 0, 0, 0, 0, 0, 1);

    @(posedge clk);
    #1;
    row("reset_outs", O_IDLE);
    check("reset_retired", 64'(retired), 64'd0);
    check("reset_err", 64'(err_code), 64'd0);
    rst = 1'b0;
    row("idle", O_IDLE);

    // ADD, zero-wait fetch: WRITEBACK is the 4th cycle after IDLE
    instr = INSTR_ADD; w_en_rf_dec = 1'b1; wr_en_dmem_dec = 1'b0;
    imem_ack = 1'b1;
    row("add_fetch", O_FACK);
    row("add_decode", O_DEC);
    row("add_exec", O_EXE);
    row("add_wb", o(5, 0, 0, 0, 0, 1, 1, 0));
    check("add_retired", 64'(retired), 64'd1);

    // LW, dmem_ack after 3 wait cycles
    instr = INSTR_LW; w_en_rf_dec = 1'b1; wr_en_dmem_dec = 1'b0;
    imem_ack = 1'b1;
    row("lw_fetch", O_FACK);
    row("lw_decode", O_DEC);
    row("lw_exec", O_EXE);
    for (int i = 0; i < 3; i++) row("lw_mem_wait", o(4, 0, 0, 1, 0, 0, 0, 0));
    dmem_ack = 1'b1;
    row("lw_mem_ack", o(4, 0, 0, 1, 0, 0, 0, 0));
    row("lw_wb", o(5, 0, 0, 0, 0, 1, 1, 0));
    check("lw_retired", 64'(retired), 64'd2);

    // SW with both decoder enables high: only the store enable may pass
    instr = INSTR_SW; w_en_rf_dec = 1'b1; wr_en_dmem_dec = 1'b1;
    imem_ack = 1'b1;
    row("sw_fetch", O_FACK);
    row("sw_decode", O_DEC);
    row("sw_exec", O_EXE);
    row("sw_mem_wait", o(4, 0, 0, 1, 1, 0, 0, 0));
    dmem_ack = 1'b1;
    row("sw_mem_ack", o(4, 0, 0, 1, 1, 0, 1, 0));
    check("sw_retired", 64'(retired), 64'd3);

    // BEQ: pc_en in EXECUTE, FETCH right after
    instr = INSTR_BEQ; w_en_rf_dec = 1'b1; wr_en_dmem_dec = 1'b0;
    imem_ack = 1'b1;
    row("beq_fetch", O_FACK);
    row("beq_decode", O_DEC);
    row("beq_exec", o(3, 0, 0, 0, 0, 0, 1, 0));
    row("beq_next_fetch", O_FWAIT);
    check("beq_retired", 64'(retired), 64'd4);

    // Illegal opcode: HALT after DECODE, acks ignored while halted
    instr = INSTR_ILL; w_en_rf_dec = 1'b0;
    imem_ack = 1'b1;
    row("ill_fetch", O_FACK);
    row("ill_decode", O_DEC);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    row("ill_halt", O_HALT);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    row("ill_halt_hold", O_HALT);
    check("ill_err", 64'(err_code), 64'd1);
    check("ill_retired", 64'(retired), 64'd4);
    rst = 1'b1;
    row("ill_rst_cycle", O_HALT);
    check("ill_rst_err", 64'(err_code), 64'd0);
    check("ill_rst_retired", 64'(retired), 64'd0);
    rst = 1'b0;
    row("ill_rst_idle", O_IDLE);

    // imem timeout: exactly 15 FETCH cycles then HALT
    for (int i = 0; i < 15; i++) row("imem_wait", O_FWAIT);
    row("imem_to_halt", O_HALT);
    check("imem_to_err", 64'(err_code), 64'd2);
    rst = 1'b1;
    row("imem_to_rst", O_HALT);
    rst = 1'b0;
    row("imem_to_idle", O_IDLE);

    // Reset mid-FETCH drops imem_req on the next cycle
    for (int i = 0; i < 3; i++) row("midf_wait", O_FWAIT);
    rst = 1'b1;
    row("midf_rst_cycle", O_FWAIT);
    rst = 1'b0;
    row("midf_req_drop", O_IDLE);

    // dmem timeout on a load: 15 MEMORY cycles then HALT
    instr = INSTR_LW; w_en_rf_dec = 1'b1;
    imem_ack = 1'b1;
    row("dto_fetch", O_FACK);
    row("dto_decode", O_DEC);
    row("dto_exec", O_EXE);
    for (int i = 0; i < 15; i++) row("dto_mem_wait", o(4, 0, 0, 1, 0, 0, 0, 0));
    row("dto_halt", O_HALT);
    check("dto_err", 64'(err_code), 64'd3);
    check("dto_retired", 64'(retired), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
